// File: rtl/ula_acc.sv
// Accumulator ALU: single-cycle LDA/ADD/SUB/AND/OR/NOT plus bit-serial SHL/SHR.
// Define ULA_OVERFLOW_EN to drive flag_v with signed overflow for ADD/SUB.
module ula_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             flag_n_reg, flag_n_next;
    logic             flag_z_reg, flag_z_next;
    logic             flag_c_reg, flag_c_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             done_reg, done_next;

    logic [SHW-1:0]   shamt;
    logic             is_shift_op;
    logic             last_shift;
    logic             is_sub;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shl_val, shr_val;

    assign shamt       = b[SHW-1:0];
    assign is_shift_op = op[2] & op[1];
    assign last_shift  = (cnt_reg == CNT_ONE);

    // One adder serves both ADD and SUB: SUB is acc + ~b + 1.
    assign is_sub = (op == OP_SUB);
    assign b_opnd = is_sub ? ~b : b;
    assign sum    = {1'b0, acc_reg} + {1'b0, b_opnd} + (WIDTH+1)'(is_sub);

    // One-bit shifted copies of acc, zero-filled at the vacated end.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_lsb
            assign shl_val[gi] = 1'b0;
        end else begin : g_lsh
            assign shl_val[gi] = acc_reg[gi-1];
        end
        if (gi == WIDTH - 1) begin : g_msb
            assign shr_val[gi] = 1'b0;
        end else begin : g_rsh
            assign shr_val[gi] = acc_reg[gi+1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && is_shift_op && (shamt != '0)) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_next    = acc_reg;
        flag_c_next = flag_c_reg;
        cnt_next    = cnt_reg;
        dir_next    = dir_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_LDA: begin
                            acc_next    = b;
                            flag_c_next = 1'b0;
                            done_next   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            acc_next    = sum[WIDTH-1:0];
                            flag_c_next = sum[WIDTH];
                            done_next   = 1'b1;
                        end
                        OP_AND: begin
                            acc_next    = acc_reg & b;
                            flag_c_next = 1'b0;
                            done_next   = 1'b1;
                        end
                        OP_OR: begin
                            acc_next    = acc_reg | b;
                            flag_c_next = 1'b0;
                            done_next   = 1'b1;
                        end
                        OP_NOT: begin
                            acc_next    = ~acc_reg;
                            flag_c_next = 1'b0;
                            done_next   = 1'b1;
                        end
                        default: begin
                            // Zero-count shift completes at once; otherwise latch count and direction.
                            if (shamt == '0) begin
                                done_next = 1'b1;
                            end else begin
                                cnt_next = shamt;
                                dir_next = op[0];
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                acc_next    = dir_reg ? shr_val : shl_val;
                flag_c_next = dir_reg ? acc_reg[0] : acc_reg[WIDTH-1];
                cnt_next    = cnt_reg - CNT_ONE;
                done_next   = last_shift;
            end
            default: ;
        endcase
        flag_n_next = acc_next[WIDTH-1];
        flag_z_next = (acc_next == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg    <= '0;
            flag_n_reg <= 1'b0;
            flag_z_reg <= 1'b1;
            flag_c_reg <= 1'b0;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            acc_reg    <= acc_next;
            flag_n_reg <= flag_n_next;
            flag_z_reg <= flag_z_next;
            flag_c_reg <= flag_c_next;
            cnt_reg    <= cnt_next;
            dir_reg    <= dir_next;
            done_reg   <= done_next;
        end
    end

`ifdef ULA_OVERFLOW_EN
    logic flag_v_reg, flag_v_next;
    logic ovf;

    // Overflow: operand signs agree (b as presented to the adder) but the sum's sign differs.
    assign ovf = (acc_reg[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != acc_reg[WIDTH-1]);

    always_comb begin
        flag_v_next = flag_v_reg;
        if (state_reg == IDLE) begin
            if (start) begin
                if ((op == OP_ADD) || (op == OP_SUB)) begin
                    flag_v_next = ovf;
                end else if (!(is_shift_op && (shamt != '0))) begin
                    flag_v_next = 1'b0;
                end
            end
        end else if (last_shift) begin
            flag_v_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_v_reg <= 1'b0;
        end else begin
            flag_v_reg <= flag_v_next;
        end
    end

    assign flag_v = flag_v_reg;
`else
    assign flag_v = 1'b0;
`endif

    assign acc    = acc_reg;
    assign busy   = (state_reg == SHIFT);
    assign done   = done_reg;
    assign flag_n = flag_n_reg;
    assign flag_z = flag_z_reg;
    assign flag_c = flag_c_reg;

endmodule

// File: tb/tb_ula_acc.sv
// Directed bench for ula_acc (WIDTH=8): arithmetic model checked every cycle plus literal spot checks.
module tb_ula_acc;

    localparam int W = 8;
    localparam bit OVF =
`ifdef ULA_OVERFLOW_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [2:0] LDA = 3'd0, ADD = 3'd1, SUB = 3'd2, ANDO = 3'd3,
                           ORO = 3'd4, NOTO = 3'd5, SHL = 3'd6, SHR = 3'd7;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         busy, done, flag_n, flag_z, flag_c, flag_v;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    ula_acc #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .b(b),
        .acc(acc), .busy(busy), .done(done),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic: returns {c, v, result}.
    function automatic logic [W+1:0] alu_model(input logic [2:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] bb);
        int ua, ub, r, sa, sb, sr;
        logic c, v;
        ua = a; ub = bb; sa = $signed(a); sb = $signed(bb);
        c = 1'b0; v = 1'b0; r = 0; sr = 0;
        case (o)
            LDA:  r = ub;
            ADD:  begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            SUB:  begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            ANDO: r = ua & ub;
            ORO:  r = ua | ub;
            NOTO: r = 255 - ua;
            default: r = ua;
        endcase
        return {c, OVF ? v : 1'b0, r[W-1:0]};
    endfunction

    function automatic logic [W-1:0] shifted(input logic [W-1:0] a0, input logic dir, input int step);
        return dir ? (a0 >> step) : (a0 << step);
    endfunction

    function automatic logic shift_out(input logic [W-1:0] a0, input logic dir, input int step);
        return dir ? a0[step-1] : a0[W-step];
    endfunction

    logic [W-1:0] m_acc, m_acc0;
    logic         m_c, m_v, m_busy, m_done, m_dir;
    int           m_k, m_rem;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc <= '0; m_acc0 <= '0; m_c <= 1'b0; m_v <= 1'b0;
            m_busy <= 1'b0; m_done <= 1'b0; m_dir <= 1'b0; m_k <= 0; m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_acc <= shifted(m_acc0, m_dir, m_k - m_rem + 1);
                m_c   <= shift_out(m_acc0, m_dir, m_k - m_rem + 1);
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_v <= 1'b0;
                end
            end else if (start) begin
                if (op == SHL || op == SHR) begin
                    if (b[2:0] == 3'd0) begin
                        m_done <= 1'b1; m_v <= 1'b0;
                    end else begin
                        m_busy <= 1'b1; m_k <= int'(b[2:0]); m_rem <= int'(b[2:0]);
                        m_dir <= (op == SHR); m_acc0 <= m_acc;
                    end
                end else begin
                    {m_c, m_v, m_acc} <= alu_model(op, m_acc, b);
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && run) begin
            chk("acc", 32'(acc), 32'(m_acc));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("flag_n", 32'(flag_n), 32'(m_acc[W-1]));
            chk("flag_z", 32'(flag_z), 32'(m_acc == '0));
            chk("flag_c", 32'(flag_c), 32'(m_c));
            chk("flag_v", 32'(flag_v), 32'(m_v));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] bb);
        start = 1'b1; op = o; b = bb;
        @(negedge clk);
        start = 1'b0;
        $display("txn op=%0d b=%02h -> acc=%02h nzcv=%b%b%b%b busy=%b done=%b",
                 o, bb, acc, flag_n, flag_z, flag_c, flag_v, busy, done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; start = 1'b0; op = 3'd0; b = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_acc", 32'(acc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_z", 32'(flag_z), 32'h1);
        chk("rst_nc_v", 32'({flag_n, flag_c, flag_v}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run = 1'b1;

        issue(LDA, 8'h7F);
        chk("lda_acc", 32'(acc), 32'h7F);
        issue(ADD, 8'h01);
        chk("add_acc", 32'(acc), 32'h80);
        chk("add_nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), OVF ? 32'b1001 : 32'b1000);
        chk("add_done", 32'(done), 32'h1);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_acc", 32'(acc), 32'h80);

        issue(LDA, 8'h05);
        issue(SUB, 8'h05);
        chk("sub0_acc", 32'(acc), 32'h00);
        chk("sub0_zc", 32'({flag_z, flag_c}), 32'b11);
        issue(SUB, 8'h01);
        chk("sub1_acc", 32'(acc), 32'hFF);
        chk("sub1_nc", 32'({flag_n, flag_c}), 32'b10);

        // SHL by 3 with start pulses that must be ignored mid-shift
        issue(LDA, 8'h81);
        issue(SHL, 8'h03);
        chk("shl_busy0", 32'({busy, done}), 32'b10);
        chk("shl_acc0", 32'(acc), 32'h81);
        start = 1'b1; op = LDA; b = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        chk("shl_acc1", 32'(acc), 32'h02);
        chk("shl_c1", 32'(flag_c), 32'h1);
        @(negedge clk);
        chk("shl_busy2", 32'(busy), 32'h1);
        start = 1'b1; op = ORO; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        chk("shl_acc", 32'(acc), 32'h08);
        chk("shl_busy_done", 32'({busy, done, flag_c}), 32'b010);
        $display("txn op=6 b=03 -> acc=%02h c=%b done=%b", acc, flag_c, done);

        // k=0 shift completes in one edge and keeps carry
        issue(LDA, 8'hFF);
        issue(ADD, 8'h02);
        chk("c_set", 32'({acc, flag_c}), 32'h003);
        issue(SHR, 8'h08);
        chk("shr0", 32'({acc, busy, done, flag_c}), 32'h00B);

        // Reset mid-shift
        issue(LDA, 8'hF0);
        issue(SHR, 8'h05);
        @(negedge clk);
        chk("shr_acc1", 32'(acc), 32'h78);
        @(negedge clk);
        chk("shr_acc2", 32'(acc), 32'h3C);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_acc", 32'(acc), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_z", 32'(flag_z), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        issue(LDA, 8'h5A);
        chk("post_rst_lda", 32'(acc), 32'h5A);

        // Back-to-back ADD, AND, NOT with start held high
        issue(LDA, 8'h0F);
        issue(ADD, 8'h01);
        chk("b2b_add", 32'({acc, done}), 32'h021);
        issue(ANDO, 8'h30);
        chk("b2b_and", 32'({acc, done}), 32'h021);
        issue(NOTO, 8'h00);
        chk("b2b_not", 32'({acc, done, flag_n}), 32'h3BF);
        issue(ORO, 8'h10);
        chk("or_acc", 32'(acc), 32'hFF);
        @(negedge clk);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
